// File: rtl/fullsub_serial.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fullsub_serial : bit-serial subtractor, diff = a - b - b_in, LSB first      |
// | Optional signed-overflow output: define FULLSUB_OVF_EN.  Rev 1.0            |
// +----------------------------------------------------------------------------+
module fullsub_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef FULLSUB_OVF_EN
  output logic             ovf,
`endif
  output logic             b_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res, res_nxt;
  logic [CW-1:0]    cnt;
  logic             br, br_nxt, d, last, accept;

`ifdef FULLSUB_OVF_EN
  logic a_msb, b_msb;
`endif

  // One full-subtractor cell; the new bit enters the result from the MSB end
  always_comb begin
    d                = a_sr[0] ^ b_sr[0] ^ br;
    br_nxt           = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    last             = (cnt == CW'(WIDTH - 1));
    res_nxt          = res >> 1;
    res_nxt[WIDTH-1] = d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        // A new request here chains straight into SHIFT without a bubble
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_sr  <= '0;
      b_sr  <= '0;
      res   <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      b_out <= 1'b0;
`ifdef FULLSUB_OVF_EN
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
`endif
    end else if (accept) begin
      a_sr <= a;
      b_sr <= b;
      br   <= b_in;
      cnt  <= '0;
`ifdef FULLSUB_OVF_EN
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
`endif
    end else if (state == SHIFT) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      br   <= br_nxt;
      res  <= res_nxt;
      cnt  <= cnt + CW'(1);
      if (last) begin
        diff  <= res_nxt;
        b_out <= br_nxt;
`ifdef FULLSUB_OVF_EN
        // d is the result MSB on the final step
        ovf   <= (a_msb ^ b_msb) & (a_msb ^ d);
`endif
      end
    end
  end

endmodule
`default_nettype wire
